multi_channel_correlator: RTL and testbench

//  Parametrised next-generation photon-arrival correlator for state detection. Gates NUM_CH PMT

---
 rtl/correlator_pkg.sv | 18 +
 rtl/correlator_channel.sv | 94 +++++++++
 rtl/multi_channel_correlator.sv | 125 ++++++++++++
 tb/tb_multi_channel_correlator.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/correlator_pkg.sv
// Shared types for the multi-channel photon correlator: one-hot FSM states
// and the per-channel arrival code values.
package correlator_pkg;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_ARM  = 5'b00010,
        ST_WIN1 = 5'b00100,
        ST_WIN2 = 5'b01000,
        ST_DONE = 5'b10000
    } state_e;

    localparam logic [1:0] ARR_NONE       = 2'd0;
    localparam logic [1:0] ARR_WIN1       = 2'd1;
    localparam logic [1:0] ARR_WIN2_ONE   = 2'd2;
    localparam logic [1:0] ARR_WIN2_MULTI = 2'd3;

endpackage

// File: rtl/correlator_channel.sv
// One PMT channel: synchroniser, rising-edge detect, saturating per-window
// counters, first-arrival capture and arrival/bright decode.
module correlator_channel
    import correlator_pkg::*;
#(
    parameter int TS_W  = 32,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pmt,
    input  logic             i_clear,
    input  logic             i_win1,
    input  logic             i_win2,
    input  logic             i_load,
    input  logic [TS_W-1:0]  i_elapsed,
    input  logic [CNT_W-1:0] i_thr,
    output logic             o_seen1_d,
    output logic [CNT_W-1:0] o_count1,
    output logic [CNT_W-1:0] o_count2,
    output logic [TS_W-1:0]  o_first_time,
    output logic [1:0]       o_arrival,
    output logic             o_bright
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             edge_q;
    logic             rise;
    logic [CNT_W-1:0] count1_q, count1_d;
    logic [CNT_W-1:0] count2_q, count2_d;
    logic [TS_W-1:0]  first_q, first_d;
    logic [1:0]       arrival_q, arrival_d;
    logic             bright_q, bright_d;
    logic [CNT_W-1:0] thr_eff;

    assign rise    = sync_q[1] & ~edge_q;
    // A zero threshold would make every channel bright, so it is treated as one.
    assign thr_eff = (i_thr == '0) ? CNT_ONE : i_thr;

    always_comb begin
        count1_d = count1_q;
        count2_d = count2_q;
        first_d  = first_q;
        if (i_clear) begin
            count1_d = '0;
            count2_d = '0;
            first_d  = '1;
        end else if (rise) begin
            if (i_win1 && count1_q != CNT_MAX) count1_d = count1_q + CNT_ONE;
            if (i_win2 && count2_q != CNT_MAX) count2_d = count2_q + CNT_ONE;
            if ((i_win1 || i_win2) && count1_q == '0 && count2_q == '0) first_d = i_elapsed;
        end

        if (count1_d != '0)           arrival_d = ARR_WIN1;
        else if (count2_d == CNT_ONE) arrival_d = ARR_WIN2_ONE;
        else if (count2_d != '0)      arrival_d = ARR_WIN2_MULTI;
        else                          arrival_d = ARR_NONE;
        bright_d = (count1_d >= thr_eff);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q    <= '0;
            edge_q    <= 1'b0;
            count1_q  <= '0;
            count2_q  <= '0;
            first_q   <= '1;
            arrival_q <= ARR_NONE;
            bright_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], i_pmt};
            edge_q   <= sync_q[1];
            count1_q <= count1_d;
            count2_q <= count2_d;
            first_q  <= first_d;
            // Decode uses next-state counts so the final window cycle is included.
            if (i_load) begin
                arrival_q <= arrival_d;
                bright_q  <= bright_d;
            end
        end
    end

    assign o_seen1_d    = (count1_d != '0);
    assign o_count1     = count1_q;
    assign o_count2     = count2_q;
    assign o_first_time = first_q;
    assign o_arrival    = arrival_q;
    assign o_bright     = bright_q;

endmodule

// File: rtl/multi_channel_correlator.sv
// Two-window photon-arrival correlator: owns the sequencing FSM, elapsed
// counter and latched configuration; per-channel work lives in correlator_channel.
module multi_channel_correlator
    import correlator_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TS_W   = 32,
    parameter int CNT_W  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic                    i_early_exit,
    input  logic [NUM_CH-1:0]       i_pmt,
    input  logic [TS_W-1:0]         i_tau1,
    input  logic [TS_W-1:0]         i_tau2,
    input  logic [CNT_W-1:0]        i_bright_thr,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_aborted,
    output logic [NUM_CH*CNT_W-1:0] o_count1,
    output logic [NUM_CH*CNT_W-1:0] o_count2,
    output logic [NUM_CH*TS_W-1:0]  o_first_time,
    output logic [NUM_CH*2-1:0]     o_arrival,
    output logic [NUM_CH-1:0]       o_bright
);

    state_e            state_q, state_d;
    logic [TS_W-1:0]   elapsed_q;
    logic [TS_W-1:0]   tau1_q, tau2_q;
    logic [CNT_W-1:0]  thr_q;
    logic              early_q;
    logic              aborted_q, done_q, busy_q;
    logic [TS_W:0]     tau_sum;
    logic              arm_enter, load, stop_hit, win1_end, win2_end;
    logic [NUM_CH-1:0] seen1;

    // The sum is one bit wider so tau1+tau2 cannot wrap before the compare.
    assign tau_sum   = {1'b0, tau1_q} + {1'b0, tau2_q};
    assign win1_end  = (elapsed_q == tau1_q - TS_W'(1));
    assign win2_end  = ({1'b0, elapsed_q} == tau_sum - (TS_W+1)'(1));
    assign arm_enter = (state_q == ST_IDLE) && i_start;
    assign stop_hit  = i_stop && (state_q == ST_ARM || state_q == ST_WIN1 || state_q == ST_WIN2);
    assign load      = (state_d == ST_DONE) && (state_q != ST_DONE);

    // Stop is checked first so it wins over window-end and early-exit exits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start) state_d = ST_ARM;
            ST_ARM: begin
                if (i_stop)              state_d = ST_DONE;
                else if (tau1_q != '0)   state_d = ST_WIN1;
                else if (tau2_q != '0)   state_d = ST_WIN2;
                else                     state_d = ST_DONE;
            end
            ST_WIN1: begin
                if (i_stop)                   state_d = ST_DONE;
                else if (early_q && &seen1)   state_d = ST_DONE;
                else if (win1_end)            state_d = (tau2_q != '0) ? ST_WIN2 : ST_DONE;
            end
            ST_WIN2: if (i_stop || win2_end) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            elapsed_q <= '0;
            tau1_q    <= '0;
            tau2_q    <= '0;
            thr_q     <= '0;
            early_q   <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == ST_DONE);
            busy_q  <= (state_d != ST_IDLE);
            if (arm_enter) begin
                tau1_q    <= i_tau1;
                tau2_q    <= i_tau2;
                thr_q     <= i_bright_thr;
                early_q   <= i_early_exit;
                aborted_q <= 1'b0;
                elapsed_q <= '0;
            end else if (state_q == ST_WIN1 || state_q == ST_WIN2) begin
                elapsed_q <= elapsed_q + TS_W'(1);
            end
            if (load) aborted_q <= stop_hit;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        correlator_channel #(
            .TS_W  (TS_W),
            .CNT_W (CNT_W)
        ) u_channel (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_pmt        (i_pmt[g]),
            .i_clear      (arm_enter),
            .i_win1       (state_q == ST_WIN1),
            .i_win2       (state_q == ST_WIN2),
            .i_load       (load),
            .i_elapsed    (elapsed_q),
            .i_thr        (thr_q),
            .o_seen1_d    (seen1[g]),
            .o_count1     (o_count1[g*CNT_W +: CNT_W]),
            .o_count2     (o_count2[g*CNT_W +: CNT_W]),
            .o_first_time (o_first_time[g*TS_W +: TS_W]),
            .o_arrival    (o_arrival[g*2 +: 2]),
            .o_bright     (o_bright[g])
        );
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_aborted = aborted_q;

endmodule

// File: tb/tb_multi_channel_correlator.sv
// Directed bench for multi_channel_correlator; a second CNT_W=2 instance
// shares every input so counter saturation can be observed cheaply.
module tb_multi_channel_correlator;

    localparam logic [127:0] ALL_ONES = '1;

    logic         clk = 1'b0;
    logic         rst, start, stop, early;
    logic [3:0]   pmt;
    logic [31:0]  tau1, tau2;
    logic [7:0]   thr;
    logic [1:0]   thrSmall;
    logic         busy, done, aborted;
    logic [31:0]  count1, count2;
    logic [127:0] firstTime;
    logic [7:0]   arrival;
    logic [3:0]   bright;
    logic         sBusy, sDone, sAborted;
    logic [7:0]   sCount1, sCount2;
    logic [127:0] sFirstTime;
    logic [7:0]   sArrival;
    logic [3:0]   sBright;

    logic [3:0]   sched [0:63];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;
    assign thrSmall = thr[1:0];

    multi_channel_correlator dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_early_exit(early),
        .i_pmt(pmt), .i_tau1(tau1), .i_tau2(tau2), .i_bright_thr(thr),
        .o_busy(busy), .o_done(done), .o_aborted(aborted), .o_count1(count1),
        .o_count2(count2), .o_first_time(firstTime), .o_arrival(arrival), .o_bright(bright)
    );

    multi_channel_correlator #(.NUM_CH(4), .TS_W(32), .CNT_W(2)) dutSmall (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_early_exit(early),
        .i_pmt(pmt), .i_tau1(tau1), .i_tau2(tau2), .i_bright_thr(thrSmall),
        .o_busy(sBusy), .o_done(sDone), .o_aborted(sAborted), .o_count1(sCount1),
        .o_count2(sCount2), .o_first_time(sFirstTime), .o_arrival(sArrival), .o_bright(sBright)
    );

    // Clears the per-cycle PMT pulse table; entry c is driven during cycle c of a run.
    task automatic clearSched();
        for (int i = 0; i < 64; i++) sched[i] = 4'b0000;
    endtask

    // Starts one run (cycle 0 = start high in IDLE) and plays the pulse table,
    // stop and reset strobes; returns the cycle o_done was seen, or -1.
    task automatic applyStimulus(input logic [31:0] t1, input logic [31:0] t2,
                                 input logic [7:0] th, input logic ee,
                                 input int stopAt, input int rstAt, input int maxCyc,
                                 output int doneCyc);
        tau1 = t1; tau2 = t2; thr = th; early = ee;
        start = 1'b1; pmt = sched[0]; stop = (stopAt == 0); rst = 1'b0;
        doneCyc = -1;
        for (int c = 1; c <= maxCyc; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            pmt   = (c < 64) ? sched[c] : 4'b0000;
            stop  = (c == stopAt);
            rst   = (c == rstAt);
            if (done === 1'b1) begin
                doneCyc = c;
                break;
            end
        end
        pmt = 4'b0000; stop = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; early = 1'b0; pmt = 4'b0000;
        tau1 = 32'd0; tau2 = 32'd0; thr = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        checks++; if (aborted !== 1'b0) begin errors++; $display("[TB] FAIL reset_aborted: got %0b expected 0", aborted); end
        checks++; if (count1 !== 32'd0 || count2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_counts: got %0h/%0h expected 0/0", count1, count2); end
        checks++; if (firstTime !== ALL_ONES) begin errors++; $display("[TB] FAIL reset_first: got %0h expected all-ones", firstTime); end
        checks++; if (arrival !== 8'h00 || bright !== 4'h0) begin errors++; $display("[TB] FAIL reset_arr_bright: got %0h/%0h expected 0/0", arrival, bright); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_no_pulses();
        int d;
        clearSched();
        applyStimulus(32'd10, 32'd20, 8'd1, 1'b0, -1, -1, 60, d);
        checks++; if (d !== 32) begin errors++; $display("[TB] FAIL nop_latency: got %0d expected 32", d); end
        checks++; if (count1 !== 32'd0 || count2 !== 32'd0) begin errors++; $display("[TB] FAIL nop_counts: got %0h/%0h expected 0/0", count1, count2); end
        checks++; if (firstTime !== ALL_ONES) begin errors++; $display("[TB] FAIL nop_first: got %0h expected all-ones", firstTime); end
        checks++; if (arrival !== 8'h00 || bright !== 4'h0) begin errors++; $display("[TB] FAIL nop_arr_bright: got %0h/%0h expected 0/0", arrival, bright); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL nop_after_done: got done=%0b busy=%0b expected 0/0", done, busy); end
    endtask

    task automatic test_windows();
        int d;
        clearSched();
        sched[3] = 4'b0001; sched[12] = 4'b0010; sched[15] = 4'b0010; sched[20] = 4'b0100;
        applyStimulus(32'd10, 32'd20, 8'd1, 1'b0, -1, -1, 60, d);
        checks++; if (d !== 32) begin errors++; $display("[TB] FAIL win_latency: got %0d expected 32", d); end
        checks++; if (count1 !== 32'h0000_0001) begin errors++; $display("[TB] FAIL win_count1: got %0h expected 1", count1); end
        checks++; if (count2 !== 32'h0001_0200) begin errors++; $display("[TB] FAIL win_count2: got %0h expected 10200", count2); end
        checks++; if (firstTime !== {32'hFFFF_FFFF, 32'd20, 32'd12, 32'd3}) begin errors++; $display("[TB] FAIL win_first: got %0h", firstTime); end
        checks++; if (arrival !== 8'h2D) begin errors++; $display("[TB] FAIL win_arrival: got %0h expected 2d", arrival); end
        checks++; if (bright !== 4'b0001) begin errors++; $display("[TB] FAIL win_bright: got %0b expected 0001", bright); end
        checks++; if (sCount2 !== 8'h18) begin errors++; $display("[TB] FAIL win_small_count2: got %0h expected 18", sCount2); end
    endtask

    task automatic test_early_exit();
        int d;
        clearSched();
        sched[1] = 4'b0001; sched[2] = 4'b0010; sched[3] = 4'b0100; sched[5] = 4'b1000;
        applyStimulus(32'd100, 32'd10, 8'd0, 1'b1, -1, -1, 200, d);
        checks++; if (d !== 8) begin errors++; $display("[TB] FAIL early_latency: got %0d expected 8", d); end
        checks++; if (aborted !== 1'b0) begin errors++; $display("[TB] FAIL early_aborted: got %0b expected 0", aborted); end
        checks++; if (count1 !== 32'h0101_0101) begin errors++; $display("[TB] FAIL early_count1: got %0h expected 01010101", count1); end
        checks++; if (firstTime !== {32'd5, 32'd3, 32'd2, 32'd1}) begin errors++; $display("[TB] FAIL early_first: got %0h", firstTime); end
        checks++; if (arrival !== 8'h55 || bright !== 4'hF) begin errors++; $display("[TB] FAIL early_arr_bright: got %0h/%0h expected 55/f", arrival, bright); end
    endtask

    task automatic test_stop();
        int d;
        clearSched();
        sched[4] = 4'b0100;
        applyStimulus(32'd20, 32'd10, 8'd1, 1'b0, 9, -1, 60, d);
        checks++; if (d !== 10) begin errors++; $display("[TB] FAIL stop_latency: got %0d expected 10", d); end
        checks++; if (aborted !== 1'b1) begin errors++; $display("[TB] FAIL stop_aborted: got %0b expected 1", aborted); end
        checks++; if (count1 !== 32'h0001_0000) begin errors++; $display("[TB] FAIL stop_count1: got %0h expected 10000", count1); end
        checks++; if (firstTime !== {32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin errors++; $display("[TB] FAIL stop_first: got %0h", firstTime); end
        checks++; if (arrival !== 8'h10 || bright !== 4'b0100) begin errors++; $display("[TB] FAIL stop_arr_bright: got %0h/%0h expected 10/4", arrival, bright); end
        clearSched();
        applyStimulus(32'd2, 32'd2, 8'd1, 1'b0, 5, -1, 30, d);
        checks++; if (d !== 6) begin errors++; $display("[TB] FAIL stop_at_end_latency: got %0d expected 6", d); end
        checks++; if (aborted !== 1'b1) begin errors++; $display("[TB] FAIL stop_beats_end: got %0b expected 1", aborted); end
    endtask

    task automatic test_zero_taus();
        int d;
        clearSched();
        applyStimulus(32'd0, 32'd0, 8'd1, 1'b0, -1, -1, 20, d);
        checks++; if (d !== 2) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected 2", d); end
        checks++; if (aborted !== 1'b0) begin errors++; $display("[TB] FAIL zero_aborted_cleared: got %0b expected 0", aborted); end
        sched[1] = 4'b0001;
        applyStimulus(32'd0, 32'd5, 8'd1, 1'b0, -1, -1, 20, d);
        checks++; if (d !== 7) begin errors++; $display("[TB] FAIL skip1_latency: got %0d expected 7", d); end
        checks++; if (count1 !== 32'd0 || count2 !== 32'd1) begin errors++; $display("[TB] FAIL skip1_counts: got %0h/%0h expected 0/1", count1, count2); end
        checks++; if (arrival !== 8'h02 || firstTime[31:0] !== 32'd1) begin errors++; $display("[TB] FAIL skip1_arr_first: got %0h/%0h expected 2/1", arrival, firstTime[31:0]); end
    endtask

    task automatic test_back_to_back();
        int doneAt [0:1];
        int nDone;
        nDone = 0; doneAt[0] = -1; doneAt[1] = -1;
        tau1 = 32'd2; tau2 = 32'd1; thr = 8'd1; early = 1'b0; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (nDone < 2) doneAt[nDone] = c;
                nDone++;
                if (nDone == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        checks++; if (nDone !== 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", nDone); end
        checks++; if (doneAt[0] !== 5 || doneAt[1] !== 11) begin errors++; $display("[TB] FAIL b2b_times: got %0d,%0d expected 5,11", doneAt[0], doneAt[1]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_saturation_and_reset();
        int d;
        clearSched();
        for (int i = 0; i < 6; i++) sched[2*i] = 4'b0001;
        applyStimulus(32'd20, 32'd5, 8'd1, 1'b0, -1, -1, 60, d);
        checks++; if (d !== 27) begin errors++; $display("[TB] FAIL sat_latency: got %0d expected 27", d); end
        checks++; if (count1[7:0] !== 8'd6) begin errors++; $display("[TB] FAIL sat_wide_count1: got %0d expected 6", count1[7:0]); end
        checks++; if (sCount1[1:0] !== 2'd3) begin errors++; $display("[TB] FAIL sat_small_count1: got %0d expected 3", sCount1[1:0]); end
        checks++; if (sArrival[1:0] !== 2'd1 || bright[0] !== 1'b1) begin errors++; $display("[TB] FAIL sat_arr_bright: got %0d/%0b expected 1/1", sArrival[1:0], bright[0]); end
        clearSched();
        sched[1] = 4'b0010; sched[9] = 4'b0010;
        applyStimulus(32'd5, 32'd20, 8'd1, 1'b0, -1, 12, 40, d);
        checks++; if (d !== -1) begin errors++; $display("[TB] FAIL rst_no_done: got %0d expected -1", d); end
        checks++; if (count1 !== 32'd0 || count2 !== 32'd0 || sCount1 !== 8'd0) begin errors++; $display("[TB] FAIL rst_counts: got %0h/%0h/%0h expected 0", count1, count2, sCount1); end
        checks++; if (firstTime !== ALL_ONES) begin errors++; $display("[TB] FAIL rst_first: got %0h expected all-ones", firstTime); end
        checks++; if (arrival !== 8'h00 || bright !== 4'h0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_outputs: got arr=%0h bright=%0h busy=%0b expected 0", arrival, bright, busy); end
    endtask

    initial begin
        test_reset();
        test_no_pulses();
        test_windows();
        test_early_exit();
        test_stop();
        test_zero_taus();
        test_back_to_back();
        test_saturation_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
